// File: rtl/lpif_dstrm_arbiter.sv
// Round-robin arbiter sharing the LPIF downstream channel among up to four requesters,
// with link bring-up sequencing, credit gating and packet-granular grant hold.
module lpif_dstrm_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int CREDIT_WIDTH = 8
) (
    input  logic                          clk_wr,
    input  logic                          rst_wr,
    input  logic                          tx_online,
    input  logic [CREDIT_WIDTH-1:0]       init_downstream_credit,
    input  logic                          credit_return,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [3:0]                    dstrm_state,
    output logic [1:0]                    dstrm_protid,
    output logic [DATA_WIDTH-1:0]         dstrm_data,
    output logic                          dstrm_dvalid,
    output logic                          dstrm_valid,
    output logic [CREDIT_WIDTH-1:0]       credit_count,
    output logic [31:0]                   arb_debug_status
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARB   = 2'd2,
        ST_BURST = 2'd3
    } state_e;

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_ZERO = {CREDIT_WIDTH{1'b0}};
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE  = {{(CREDIT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX  = {CREDIT_WIDTH{1'b1}};
    localparam logic [1:0]              LAST_IDX    = 2'(NUM_REQ - 1);

    state_e                  state_q, state_d;
    logic [1:0]              rr_ptr_q, rr_ptr_d;
    logic [1:0]              grant_idx_q, grant_idx_d;
    logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
    logic [15:0]             beat_cnt_q, beat_cnt_d;
    logic [3:0]              dstrm_state_q, dstrm_state_d;
    logic [1:0]              protid_q, protid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;

    logic [3:0]              valid_pad_s, last_pad_s, ready_s;
    logic [1:0]              cand_s, grant_s, sel_idx_s, next_rr_s;
    logic                    grant_found_s, accept_s, sel_last_s;
    logic [DATA_WIDTH-1:0]   sel_data_s;

    // Circular search from rr_ptr, ready generation and accepted-beat selection
    always_comb begin
        valid_pad_s                = 4'b0000;
        last_pad_s                 = 4'b0000;
        valid_pad_s[NUM_REQ-1:0]   = req_valid;
        last_pad_s[NUM_REQ-1:0]    = req_last;
        cand_s                     = 2'd0;
        grant_s                    = rr_ptr_q;
        grant_found_s              = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s        = 2'((int'(rr_ptr_q) + k) % NUM_REQ);
            grant_s       = (valid_pad_s[cand_s] && !grant_found_s) ? cand_s : grant_s;
            grant_found_s = grant_found_s | valid_pad_s[cand_s];
        end

        ready_s = 4'b0000;
        case (state_q)
            ST_ARB: begin
                if (grant_found_s && (credit_q != CREDIT_ZERO)) ready_s[grant_s] = 1'b1;
                else                                            ready_s = 4'b0000;
            end
            ST_BURST: begin
                if (credit_q != CREDIT_ZERO) ready_s[grant_idx_q] = 1'b1;
                else                         ready_s = 4'b0000;
            end
            default: ready_s = 4'b0000;
        endcase

        sel_idx_s  = (state_q == ST_BURST) ? grant_idx_q : grant_s;
        accept_s   = |(ready_s & valid_pad_s);
        sel_last_s = last_pad_s[sel_idx_s];
        next_rr_s  = (sel_idx_s == LAST_IDX) ? 2'd0 : sel_idx_s + 2'd1;
        sel_data_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data_s = (2'(i) == sel_idx_s) ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : sel_data_s;
        end
    end

    // Next-state, credit, pointer and output-register computation
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_idx_d   = grant_idx_q;
        credit_d      = credit_q;
        case (state_q)
            ST_IDLE: begin
                state_d  = tx_online ? ST_LOAD : ST_IDLE;
                credit_d = CREDIT_ZERO;
            end
            ST_LOAD: begin
                state_d  = ST_ARB;
                credit_d = init_downstream_credit;
            end
            ST_ARB: begin
                if (accept_s && sel_last_s) begin
                    rr_ptr_d = next_rr_s;
                end else if (accept_s) begin
                    state_d     = ST_BURST;
                    grant_idx_d = grant_s;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_BURST: begin
                if (accept_s && sel_last_s) begin
                    rr_ptr_d = next_rr_s;
                    state_d  = ST_ARB;
                end else begin
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = CREDIT_ZERO;
            end
        endcase

        // Accept and return in the same cycle cancel; the counter saturates at max
        if ((state_q == ST_ARB) || (state_q == ST_BURST)) begin
            if (accept_s && !credit_return)                               credit_d = credit_q - CREDIT_ONE;
            else if (!accept_s && credit_return && credit_q != CREDIT_MAX) credit_d = credit_q + CREDIT_ONE;
            else                                                          credit_d = credit_q;
        end else begin
            credit_d = credit_d;
        end

        if (!tx_online) begin
            state_d     = ST_IDLE;
            credit_d    = CREDIT_ZERO;
            grant_idx_d = 2'd0;
        end else begin
            state_d = state_d;
        end

        beat_cnt_d    = accept_s ? beat_cnt_q + 16'd1 : beat_cnt_q;
        dstrm_state_d = ((state_q == ST_ARB) || (state_q == ST_BURST)) ? 4'h1 : 4'h0;
        valid_d       = accept_s;
        protid_d      = accept_s ? sel_idx_s : protid_q;
        data_d        = accept_s ? sel_data_s : data_q;
    end

    // State and output registers
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= 2'd0;
            grant_idx_q   <= 2'd0;
            credit_q      <= CREDIT_ZERO;
            beat_cnt_q    <= 16'd0;
            dstrm_state_q <= 4'h0;
            protid_q      <= 2'd0;
            data_q        <= {DATA_WIDTH{1'b0}};
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_idx_q   <= grant_idx_d;
            credit_q      <= credit_d;
            beat_cnt_q    <= beat_cnt_d;
            dstrm_state_q <= dstrm_state_d;
            protid_q      <= protid_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
        end
    end

    assign req_ready        = ready_s[NUM_REQ-1:0];
    assign dstrm_state      = dstrm_state_q;
    assign dstrm_protid     = protid_q;
    assign dstrm_data       = data_q;
    assign dstrm_valid      = valid_q;
    assign dstrm_dvalid     = valid_q;
    assign credit_count     = credit_q;
    assign arb_debug_status = {state_q, grant_idx_q, 4'h0, 8'(credit_q), beat_cnt_q};

endmodule

// File: tb/tb_lpif_dstrm_arbiter.sv
// Scenario bench for lpif_dstrm_arbiter: expected beats are queued as stimulus is
// driven and compared in order against the beats the channel presents.
module tb_lpif_dstrm_arbiter;

    logic        clk_wr = 1'b0;
    logic        rst_wr;
    logic        tx_online;
    logic [7:0]  init_downstream_credit;
    logic        credit_return;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [127:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  dstrm_state;
    logic [1:0]  dstrm_protid;
    logic [31:0] dstrm_data;
    logic        dstrm_dvalid;
    logic        dstrm_valid;
    logic [7:0]  credit_count;
    logic [31:0] arb_debug_status;

    int checks   = 0;
    int failures = 0;

    logic [34:0] exp_q[$];
    logic [34:0] obs_q[$];
    logic [34:0] o_v, e_v;

    always #5 clk_wr = ~clk_wr;

    lpif_dstrm_arbiter dut (
        .clk_wr                 (clk_wr),
        .rst_wr                 (rst_wr),
        .tx_online              (tx_online),
        .init_downstream_credit (init_downstream_credit),
        .credit_return          (credit_return),
        .req_valid              (req_valid),
        .req_last               (req_last),
        .req_data               (req_data),
        .req_ready              (req_ready),
        .dstrm_state            (dstrm_state),
        .dstrm_protid           (dstrm_protid),
        .dstrm_data             (dstrm_data),
        .dstrm_dvalid           (dstrm_dvalid),
        .dstrm_valid            (dstrm_valid),
        .credit_count           (credit_count),
        .arb_debug_status       (arb_debug_status)
    );

    // Advance one clock and capture any beat the channel presents
    task automatic tick();
        @(posedge clk_wr);
        #2;
        if (dstrm_valid === 1'b1) obs_q.push_back({dstrm_dvalid, dstrm_protid, dstrm_data});
    endtask

    task automatic expect_beat(input logic [1:0] pid, input logic [31:0] d);
        exp_q.push_back({1'b1, pid, d});
    endtask

    task automatic do_reset();
        rst_wr = 1'b1;
        tx_online = 1'b0;
        init_downstream_credit = 8'd0;
        credit_return = 1'b0;
        req_valid = 4'b0000;
        req_last = 4'b0000;
        req_data = 128'd0;
        repeat (2) @(posedge clk_wr);
        #2;
        rst_wr = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic bring_up(input logic [7:0] cred);
        init_downstream_credit = cred;
        tx_online = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        req_valid = 4'b1111;
        req_last = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++; if (dstrm_valid !== 1'b0 || dstrm_dvalid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b%b exp=00", dstrm_valid, dstrm_dvalid); end
        checks++; if (dstrm_data !== 32'd0 || dstrm_protid !== 2'd0) begin failures++; $display("FAIL reset_data got=%h/%0d exp=0/0", dstrm_data, dstrm_protid); end
        checks++; if (dstrm_state !== 4'h0) begin failures++; $display("FAIL reset_state got=%h exp=0", dstrm_state); end
        checks++; if (credit_count !== 8'd0) begin failures++; $display("FAIL reset_credit got=%0d exp=0", credit_count); end
        checks++; if (arb_debug_status !== 32'd0) begin failures++; $display("FAIL reset_debug got=%h exp=0", arb_debug_status); end
        tick();
        checks++; if (credit_count !== 8'd0 || req_ready !== 4'b0000) begin failures++; $display("FAIL idle_hold got=%0d/%b exp=0/0000", credit_count, req_ready); end
    endtask

    task automatic test_bringup();
        do_reset();
        init_downstream_credit = 8'd3;
        tx_online = 1'b1;
        tick();
        checks++; if (arb_debug_status[31:30] !== 2'd1) begin failures++; $display("FAIL bringup_load got=%0d exp=1", arb_debug_status[31:30]); end
        checks++; if (credit_count !== 8'd0) begin failures++; $display("FAIL bringup_load_credit got=%0d exp=0", credit_count); end
        tick();
        checks++; if (arb_debug_status[31:30] !== 2'd2) begin failures++; $display("FAIL bringup_arb got=%0d exp=2", arb_debug_status[31:30]); end
        checks++; if (credit_count !== 8'd3) begin failures++; $display("FAIL bringup_credit got=%0d exp=3", credit_count); end
        checks++; if (dstrm_state !== 4'h0) begin failures++; $display("FAIL bringup_state_early got=%h exp=0", dstrm_state); end
        tick();
        checks++; if (dstrm_state !== 4'h1) begin failures++; $display("FAIL bringup_state got=%h exp=1", dstrm_state); end
    endtask

    task automatic test_round_robin();
        do_reset();
        bring_up(8'd16);
        req_valid = 4'b1111;
        req_last = 4'b1111;
        req_data = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rr_ready got=%b exp=0001", req_ready); end
        expect_beat(2'd0, 32'h0000_00A0);
        expect_beat(2'd1, 32'h0000_00A1);
        expect_beat(2'd2, 32'h0000_00A2);
        expect_beat(2'd3, 32'h0000_00A3);
        expect_beat(2'd0, 32'h0000_00A0);
        repeat (5) tick();
        req_valid = 4'b0000;
        tick();
        checks++; if (credit_count !== 8'd11) begin failures++; $display("FAIL rr_credit got=%0d exp=11", credit_count); end
        checks++; if (dstrm_valid !== 1'b0) begin failures++; $display("FAIL rr_idle_valid got=%b exp=0", dstrm_valid); end
        checks++; if (dstrm_protid !== 2'd0 || dstrm_data !== 32'h0000_00A0) begin failures++; $display("FAIL rr_hold got=%0d/%h exp=0/000000a0", dstrm_protid, dstrm_data); end
        checks++; if (arb_debug_status[15:0] !== 16'd5) begin failures++; $display("FAIL rr_beat_cnt got=%0d exp=5", arb_debug_status[15:0]); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rr_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o_v = obs_q.pop_front(); e_v = exp_q.pop_front();
            checks++; if (o_v !== e_v) begin failures++; $display("FAIL rr_beat got=%h exp=%h", o_v, e_v); end
        end
    endtask

    task automatic test_burst_hold();
        do_reset();
        bring_up(8'd16);
        req_valid = 4'b0011;
        req_last = 4'b0010;
        req_data = {64'd0, 32'h0000_0E01, 32'h0000_0D00};
        expect_beat(2'd0, 32'h0000_0D00);
        expect_beat(2'd0, 32'h0000_0D01);
        expect_beat(2'd0, 32'h0000_0D02);
        expect_beat(2'd1, 32'h0000_0E01);
        tick();
        req_data[31:0] = 32'h0000_0D01;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL burst_ready got=%b exp=0001", req_ready); end
        tick();
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL burst_wait_ready got=%b exp=0001", req_ready); end
        tick();
        req_valid = 4'b0011;
        req_last = 4'b0011;
        req_data[31:0] = 32'h0000_0D02;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        tick();
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL burst_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o_v = obs_q.pop_front(); e_v = exp_q.pop_front();
            checks++; if (o_v !== e_v) begin failures++; $display("FAIL burst_beat got=%h exp=%h", o_v, e_v); end
        end
    endtask

    task automatic test_credit_exhaustion();
        do_reset();
        bring_up(8'd2);
        req_valid = 4'b0100;
        req_last = 4'b0100;
        req_data = {32'd0, 32'hC2C2_0000, 64'd0};
        repeat (4) expect_beat(2'd2, 32'hC2C2_0000);
        tick();
        tick();
        #1;
        checks++; if (req_ready !== 4'b0000 || credit_count !== 8'd0) begin failures++; $display("FAIL cred_empty got=%b/%0d exp=0000/0", req_ready, credit_count); end
        tick();
        checks++; if (dstrm_valid !== 1'b0) begin failures++; $display("FAIL cred_stall_valid got=%b exp=0", dstrm_valid); end
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        checks++; if (credit_count !== 8'd1) begin failures++; $display("FAIL cred_return got=%0d exp=1", credit_count); end
        tick();
        tick();
        checks++; if (credit_count !== 8'd0 || req_ready !== 4'b0000) begin failures++; $display("FAIL cred_one_more got=%0d/%b exp=0/0000", credit_count, req_ready); end
        credit_return = 1'b1;
        tick();
        tick();
        checks++; if (credit_count !== 8'd1) begin failures++; $display("FAIL cred_simul got=%0d exp=1", credit_count); end
        credit_return = 1'b0;
        req_valid = 4'b0000;
        tick();
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL cred_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o_v = obs_q.pop_front(); e_v = exp_q.pop_front();
            checks++; if (o_v !== e_v) begin failures++; $display("FAIL cred_beat got=%h exp=%h", o_v, e_v); end
        end
    endtask

    task automatic test_link_drop();
        do_reset();
        bring_up(8'd16);
        req_valid = 4'b0001;
        req_last = 4'b0001;
        req_data = {64'd0, 32'h0000_0B00, 32'h0000_0A00};
        expect_beat(2'd0, 32'h0000_0A00);
        expect_beat(2'd1, 32'h0000_0B00);
        expect_beat(2'd1, 32'h0000_0B01);
        expect_beat(2'd1, 32'h0000_0B02);
        tick();
        req_valid = 4'b0010;
        req_last = 4'b0000;
        tick();
        req_data[63:32] = 32'h0000_0B01;
        tick();
        tx_online = 1'b0;
        req_valid = 4'b0000;
        tick();
        checks++; if (arb_debug_status[31:30] !== 2'd0) begin failures++; $display("FAIL drop_idle got=%0d exp=0", arb_debug_status[31:30]); end
        checks++; if (credit_count !== 8'd0) begin failures++; $display("FAIL drop_credit got=%0d exp=0", credit_count); end
        req_valid = 4'b0011;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL drop_ready got=%b exp=0000", req_ready); end
        req_last = 4'b0011;
        req_data[63:32] = 32'h0000_0B02;
        bring_up(8'd5);
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL reonline_ready got=%b exp=0010", req_ready); end
        checks++; if (credit_count !== 8'd5) begin failures++; $display("FAIL reonline_credit got=%0d exp=5", credit_count); end
        tick();
        req_valid = 4'b0000;
        tick();
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL drop_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o_v = obs_q.pop_front(); e_v = exp_q.pop_front();
            checks++; if (o_v !== e_v) begin failures++; $display("FAIL drop_beat got=%h exp=%h", o_v, e_v); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bring_up(8'd16);
        req_valid = 4'b1000;
        req_last = 4'b0000;
        req_data = {32'h0000_00F0, 96'd0};
        expect_beat(2'd3, 32'h0000_00F0);
        tick();
        checks++; if (dstrm_valid !== 1'b1) begin failures++; $display("FAIL areset_pre_valid got=%b exp=1", dstrm_valid); end
        #1;
        rst_wr = 1'b1;
        #1;
        checks++; if (dstrm_valid !== 1'b0 || dstrm_dvalid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b%b exp=00", dstrm_valid, dstrm_dvalid); end
        checks++; if (dstrm_data !== 32'd0 || dstrm_protid !== 2'd0 || dstrm_state !== 4'h0) begin failures++; $display("FAIL areset_out got=%h/%0d/%h exp=0/0/0", dstrm_data, dstrm_protid, dstrm_state); end
        checks++; if (req_ready !== 4'b0000 || credit_count !== 8'd0) begin failures++; $display("FAIL areset_ready got=%b/%0d exp=0000/0", req_ready, credit_count); end
        checks++; if (arb_debug_status !== 32'd0) begin failures++; $display("FAIL areset_debug got=%h exp=0", arb_debug_status); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL areset_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o_v = obs_q.pop_front(); e_v = exp_q.pop_front();
            checks++; if (o_v !== e_v) begin failures++; $display("FAIL areset_beat got=%h exp=%h", o_v, e_v); end
        end
        rst_wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_round_robin();
        test_burst_hold();
        test_credit_exhaustion();
        test_link_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
